accelerator_vector_integer_summation: RTL
=========================================

# accelerator_vector_integer_summation

Streaming reduction stage that sums the elements of an integer vector into one scalar with a sticky unsigned overflow flag. It sits directly downstream of the vector integer adder. Its DATA_IN/DATA_IN_ENABLE inputs take that adder's DATA_OUT/DATA_OUT_ENABLE element stream, so the pair computes sum(A ± B) over a vector of SIZE_IN elements.

## Interface
- DATA_SIZE, 64, element and result width in bits
- CONTROL_SIZE, 64, width of the internal element counter and the latched size
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  begin a new reduction; sampled only in STARTER
- READY  out  1  one-cycle pulse; DATA_OUT and OVERFLOW_OUT are valid from this cycle on
- DATA_IN_ENABLE  in  1  DATA_IN carries a valid element this cycle
- DATA_ENABLE  out  1  one-cycle acknowledge that an element was consumed
- SIZE_IN  in  DATA_SIZE  number of elements; latched on START
- DATA_IN  in  DATA_SIZE  element, unsigned
- DATA_OUT  out  DATA_SIZE  sum modulo 2^DATA_SIZE
- OVERFLOW_OUT  out  1  at least one carry out of bit DATA_SIZE-1 occurred during the reduction

## Operation
- States: STARTER=0, INPUT=1, ENDER=2 (2-bit). Any other encoding goes to STARTER.
- Reset: state=STARTER. READY, DATA_ENABLE, OVERFLOW_OUT=0. DATA_OUT=0. Accumulator, counter, latched size and sticky flag=0.
- STARTER: READY<=0, DATA_ENABLE<=0.
  - On START=1 with SIZE_IN≠0: latch the size, counter<=0, accumulator<=0, sticky<=0, go to INPUT.
  - On START=1 with SIZE_IN=0: DATA_OUT<=0, OVERFLOW_OUT<=0, READY<=1, stay in STARTER.
- INPUT: on DATA_IN_ENABLE=1:
  - {carry, accumulator} <= accumulator + DATA_IN, computed at DATA_SIZE+1 bits.
  - sticky <= sticky | carry.
  - DATA_ENABLE<=1, go to ENDER.
  - Otherwise wait, with DATA_ENABLE<=0.
- ENDER: DATA_ENABLE<=0.
  - If counter == size-1: DATA_OUT<=accumulator, OVERFLOW_OUT<=sticky, READY<=1, go to STARTER.
  - Otherwise counter<=counter+1, go to INPUT.
- DATA_OUT and OVERFLOW_OUT hold their values until the next completion or reset.
- START is ignored in INPUT and ENDER. SIZE_IN changes after START have no effect on the current run.
- DATA_IN_ENABLE in STARTER or ENDER is ignored and the element is lost. Upstream guarantees at most one element per 2 cycles, which the vector adder satisfies by construction.
- RST mid-run aborts immediately to the reset values. There is no partial result.

## Timing
- Element throughput: 1 element per 2 cycles maximum.
- Element accepted at edge k → DATA_ENABLE high during cycle k..k+1.
- Last element accepted at edge k → READY and the final DATA_OUT/OVERFLOW_OUT visible after edge k+1. READY is high for exactly one cycle.
- START asserted during the READY cycle is accepted: the new run enters INPUT at the next edge.
- SIZE_IN=0: READY is high in the cycle after the START edge.
- Total latency for N elements arriving back-to-back: START edge +1 (enter INPUT) + 2N edges.

## Structure
- Shared package (accelerator_pkg) holds:
  - the 2-bit state encodings STARTER/INPUT/ENDER;
  - ZERO_CONTROL/ONE_CONTROL and ZERO_DATA/ONE_DATA constants.
- No sub-module.
  - The DATA_SIZE+1-bit add is inline, because the 2-cycle per-element cadence forbids the multi-cycle START/READY handshake of accelerator_scalar_integer_adder.
- Single clocked always block with asynchronous RST.

## Test plan
- Reset: assert RST mid-run after 2 of 4 elements → all outputs 0, state STARTER; a fresh START with SIZE_IN=3 and elements 1,2,3 → DATA_OUT=6, OVERFLOW_OUT=0.
- Basic (DATA_SIZE=64): SIZE_IN=4, elements 10,20,30,40 back-to-back every 2 cycles → four DATA_ENABLE pulses; READY one cycle after the 4th acceptance; DATA_OUT=100, OVERFLOW_OUT=0.
- Overflow (DATA_SIZE=8): SIZE_IN=3, elements 200,100,10 → DATA_OUT=54, OVERFLOW_OUT=1 (sticky across the 3rd add).
- Zero size: START with SIZE_IN=0 → READY pulse next cycle, DATA_OUT=0, no DATA_ENABLE.
- Back-to-back runs with gaps: SIZE_IN=2, elements 5 and 7 with 3 idle cycles between them → DATA_OUT=12. Raise START during the READY cycle with SIZE_IN=1, element 9 → DATA_OUT=9, OVERFLOW_OUT=0.
- Illegal stimulus: DATA_IN_ENABLE held during ENDER and STARTER → element ignored, no DATA_ENABLE; changing SIZE_IN mid-run → no effect on the count.
- Chained with the vector adder: vector A={1,2,3}, B={4,5,6}, OPERATION=add → DATA_OUT=21.

Source files
------------

// File: rtl/accelerator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accelerator_pkg
// Brief    : Shared state encodings and width-independent constants for the
//            vector accelerator stages.
// Revision : 1.0 - initial release
// ============================================================================
package accelerator_pkg;

   // Reduction/handshake FSM encodings shared by the accelerator stages
   typedef enum logic [1:0] {
      STARTER = 2'd0,
      INPUT   = 2'd1,
      ENDER   = 2'd2
   } state_t;

   // Constants are 64 bits wide; users cast them to their own widths
   localparam logic [63:0] ZERO_CONTROL = 64'd0;
   localparam logic [63:0] ONE_CONTROL  = 64'd1;
   localparam logic [63:0] ZERO_DATA    = 64'd0;
   localparam logic [63:0] ONE_DATA     = 64'd1;

endpackage : accelerator_pkg
`default_nettype wire

// File: rtl/accelerator_vector_integer_summation.sv
`default_nettype none
// ============================================================================
// Module   : accelerator_vector_integer_summation
// Brief    : Streaming reduction of an unsigned integer vector into a scalar
//            sum (mod 2^DATA_SIZE) with a sticky carry-out overflow flag.
//            Accepts at most one element every two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module accelerator_vector_integer_summation
   import accelerator_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   output logic                  READY,
   input  logic                  DATA_IN_ENABLE,
   output logic                  DATA_ENABLE,
   input  logic [DATA_SIZE-1:0]  SIZE_IN,
   input  logic [DATA_SIZE-1:0]  DATA_IN,
   output logic [DATA_SIZE-1:0]  DATA_OUT,
   output logic                  OVERFLOW_OUT
);

   localparam logic [DATA_SIZE-1:0]    ZERO_D = DATA_SIZE'(ZERO_DATA);
   localparam logic [CONTROL_SIZE-1:0] ZERO_C = CONTROL_SIZE'(ZERO_CONTROL);
   localparam logic [CONTROL_SIZE-1:0] ONE_C  = CONTROL_SIZE'(ONE_CONTROL);

   state_t                  state_q;
   logic [DATA_SIZE-1:0]    acc_q;
   logic [CONTROL_SIZE-1:0] cnt_q;
   logic [CONTROL_SIZE-1:0] size_q;
   logic                    sticky_q;
   logic                    ready_q;
   logic                    data_enable_q;
   logic [DATA_SIZE-1:0]    data_out_q;
   logic                    overflow_q;

   // One extra bit captures the carry out of the element add
   logic [DATA_SIZE:0]      sum_w;
   assign sum_w = {1'b0, acc_q} + {1'b0, DATA_IN};

   // Reduction FSM: latch size, accumulate one element per INPUT/ENDER pair,
   // publish the result and pulse READY on the last element
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= STARTER;
         acc_q         <= ZERO_D;
         cnt_q         <= ZERO_C;
         size_q        <= ZERO_C;
         sticky_q      <= 1'b0;
         ready_q       <= 1'b0;
         data_enable_q <= 1'b0;
         data_out_q    <= ZERO_D;
         overflow_q    <= 1'b0;
      end else begin
         case (state_q)
            STARTER: begin
               ready_q       <= 1'b0;
               data_enable_q <= 1'b0;
               if (START) begin
                  if (SIZE_IN != ZERO_D) begin
                     size_q   <= CONTROL_SIZE'(SIZE_IN);
                     cnt_q    <= ZERO_C;
                     acc_q    <= ZERO_D;
                     sticky_q <= 1'b0;
                     state_q  <= INPUT;
                  end else begin
                     // Empty vector completes immediately with a zero sum
                     data_out_q <= ZERO_D;
                     overflow_q <= 1'b0;
                     ready_q    <= 1'b1;
                  end
               end
            end
            INPUT: begin
               if (DATA_IN_ENABLE) begin
                  acc_q         <= sum_w[DATA_SIZE-1:0];
                  sticky_q      <= sticky_q | sum_w[DATA_SIZE];
                  data_enable_q <= 1'b1;
                  state_q       <= ENDER;
               end else begin
                  data_enable_q <= 1'b0;
               end
            end
            ENDER: begin
               data_enable_q <= 1'b0;
               if (cnt_q == size_q - ONE_C) begin
                  data_out_q <= acc_q;
                  overflow_q <= sticky_q;
                  ready_q    <= 1'b1;
                  state_q    <= STARTER;
               end else begin
                  cnt_q   <= cnt_q + ONE_C;
                  state_q <= INPUT;
               end
            end
            default: begin
               state_q <= STARTER;
            end
         endcase
      end
   end

   assign READY        = ready_q;
   assign DATA_ENABLE  = data_enable_q;
   assign DATA_OUT     = data_out_q;
   assign OVERFLOW_OUT = overflow_q;

endmodule : accelerator_vector_integer_summation
`default_nettype wire
